// File: rtl/sd_stream_pkg.sv
// Shared constants and FSM encoding for the SD sector streamer.
package sd_stream_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StWaitSpace,
    StIssue,
    StReceive,
    StDrain
  } state_e;

  localparam int unsigned SECTOR_BYTES = 512;
  localparam int unsigned SECTOR_WORDS = 128;
  localparam int unsigned WORD_BYTES   = 4;
  // Packed word plus the final-word flag in bit 32.
  localparam int unsigned FIFO_W       = 8 * WORD_BYTES + 1;

endpackage

// File: rtl/sd_sector_streamer_if.sv
// Command, SD reader and output stream signals of the sector streamer.
interface sd_sector_streamer_if;

  logic        cmd_start;
  logic [31:0] cmd_sector;
  logic [15:0] cmd_count;
  logic        busy;
  logic        done;
  logic        err;

  logic        rstart;
  logic [31:0] rsector;
  logic        rbusy;
  logic        rdone;
  logic        outen;
  logic [8:0]  outaddr;
  logic [7:0]  outbyte;

  logic        m_valid;
  logic        m_ready;
  logic [31:0] m_data;
  logic        m_last;

  // master is the streamer itself; slave is the surrounding system.
  modport master (
    input  cmd_start, cmd_sector, cmd_count, rbusy, rdone, outen, outaddr, outbyte, m_ready,
    output busy, done, err, rstart, rsector, m_valid, m_data, m_last
  );

  modport slave (
    output cmd_start, cmd_sector, cmd_count, rbusy, rdone, outen, outaddr, outbyte, m_ready,
    input  busy, done, err, rstart, rsector, m_valid, m_data, m_last
  );

endinterface

// File: rtl/sync_fifo.sv
// Synchronous FIFO with a registered first-word fall-through output stage.
module sync_fifo #(
  parameter int unsigned WIDTH = 33,
  parameter int unsigned AW    = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_rdata,
  output logic             o_valid,
  output logic             o_full,
  output logic             o_empty,
  output logic [AW:0]      o_count
);

  localparam int unsigned DEPTH = 1 << AW;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wptr;
  logic [AW-1:0]    r_rptr;
  logic [AW:0]      r_mem_cnt;
  logic [AW:0]      r_count;
  logic [WIDTH-1:0] r_dout;
  logic             r_valid;

  logic w_push;
  logic w_pop;
  logic w_load;

  assign o_full  = (r_count == (AW+1)'(DEPTH));
  assign o_empty = (r_count == '0);
  assign o_count = r_count;
  assign o_rdata = r_dout;
  assign o_valid = r_valid;

  assign w_push = i_push && !o_full;
  assign w_pop  = i_pop && r_valid;
  // r_count includes the word sitting in the output register.
  assign w_load = (r_mem_cnt != '0) && (!r_valid || w_pop);

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wptr] <= i_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wptr    <= '0;
      r_rptr    <= '0;
      r_mem_cnt <= '0;
      r_count   <= '0;
      r_dout    <= '0;
      r_valid   <= 1'b0;
    end else begin
      if (w_push) begin
        r_wptr <= r_wptr + 1'b1;
      end
      if (w_load) begin
        r_rptr  <= r_rptr + 1'b1;
        r_dout  <= r_mem[r_rptr];
        r_valid <= 1'b1;
      end else if (w_pop) begin
        r_valid <= 1'b0;
      end
      r_mem_cnt <= r_mem_cnt + (AW+1)'(w_push) - (AW+1)'(w_load);
      r_count   <= r_count + (AW+1)'(w_push) - (AW+1)'(w_pop);
    end
  end

endmodule

// File: rtl/sd_sector_streamer.sv
// Issues one-sector reads to the SD reader and packs its byte stream into a word stream.
module sd_sector_streamer
  import sd_stream_pkg::*;
#(
  parameter int unsigned FIFO_AW = 8
) (
  input logic                  clk,
  input logic                  rst,
  sd_sector_streamer_if.master bus
);

  localparam int unsigned DEPTH = 1 << FIFO_AW;

  state_e      r_state;
  state_e      w_state_d;
  logic [31:0] r_sector;
  logic [15:0] r_remaining;
  logic [9:0]  r_byte_cnt;
  logic [23:0] r_word;
  logic        r_err;
  logic        r_done;

  logic              w_capture;
  logic              w_sector_done;
  logic              w_done_d;
  logic              w_byte_en;
  logic              w_addr_bad;
  logic              w_short;
  logic              w_push;
  logic              w_last;
  logic              w_overflow;
  logic              w_err_set;
  logic              w_space_ok;
  logic [FIFO_W-1:0] w_wdata;
  logic [FIFO_W-1:0] w_rdata;
  logic              w_fifo_valid;
  logic              w_fifo_full;
  logic              w_fifo_empty;
  logic [FIFO_AW:0]  w_fifo_count;

  sync_fifo #(
    .WIDTH(FIFO_W),
    .AW   (FIFO_AW)
  ) u_fifo (
    .clk    (clk),
    .rst    (rst),
    .i_push (w_push),
    .i_wdata(w_wdata),
    .i_pop  (bus.m_ready),
    .o_rdata(w_rdata),
    .o_valid(w_fifo_valid),
    .o_full (w_fifo_full),
    .o_empty(w_fifo_empty),
    .o_count(w_fifo_count)
  );

  // The reader cannot be stalled, so a whole sector of room is reserved before issuing.
  assign w_space_ok = ((FIFO_AW+1)'(DEPTH) - w_fifo_count) >= (FIFO_AW+1)'(SECTOR_WORDS);

  assign w_byte_en  = (r_state == StReceive) && bus.outen;
  assign w_addr_bad = {1'b0, bus.outaddr} != r_byte_cnt;
  assign w_last     = (bus.outaddr == 9'd511) && (r_remaining == 16'd1);
  assign w_push     = w_byte_en && (bus.outaddr[1:0] == 2'd3);
  assign w_wdata    = {w_last, bus.outbyte, r_word};
  assign w_overflow = w_push && w_fifo_full;
  assign w_short    = (r_byte_cnt + 10'(w_byte_en)) < 10'(SECTOR_BYTES);
  assign w_err_set  = (w_byte_en && w_addr_bad) || w_overflow || (w_sector_done && w_short);

  always_comb begin
    w_state_d     = r_state;
    w_capture     = 1'b0;
    w_sector_done = 1'b0;
    w_done_d      = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (bus.cmd_start) begin
          w_capture = 1'b1;
          w_state_d = (bus.cmd_count == 16'd0) ? StDrain : StWaitSpace;
        end
      end
      StWaitSpace: begin
        if (w_space_ok && !bus.rbusy) begin
          w_state_d = StIssue;
        end
      end
      StIssue: begin
        if (bus.rbusy) begin
          w_state_d = StReceive;
        end
      end
      StReceive: begin
        if (bus.rdone) begin
          w_sector_done = 1'b1;
          w_state_d     = (r_remaining > 16'd1) ? StWaitSpace : StDrain;
        end
      end
      StDrain: begin
        if (w_fifo_empty) begin
          w_done_d  = 1'b1;
          w_state_d = StIdle;
        end
      end
      default: w_state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= StIdle;
      r_sector    <= '0;
      r_remaining <= '0;
      r_byte_cnt  <= '0;
      r_word      <= '0;
      r_err       <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_state <= w_state_d;
      r_done  <= w_done_d;

      if (w_capture) begin
        r_err <= 1'b0;
      end else if (w_err_set) begin
        r_err <= 1'b1;
      end

      if (w_capture) begin
        r_sector    <= bus.cmd_sector;
        r_remaining <= bus.cmd_count;
        r_byte_cnt  <= '0;
      end else if (w_sector_done) begin
        r_sector    <= r_sector + 32'd1;
        r_remaining <= r_remaining - 16'd1;
        r_byte_cnt  <= '0;
      end else if (w_byte_en) begin
        r_byte_cnt <= r_byte_cnt + 10'd1;
      end

      // Bytes land by their own address, even when the sequence is broken.
      if (w_byte_en) begin
        case (bus.outaddr[1:0])
          2'd0:    r_word[7:0]   <= bus.outbyte;
          2'd1:    r_word[15:8]  <= bus.outbyte;
          2'd2:    r_word[23:16] <= bus.outbyte;
          default: r_word        <= r_word;
        endcase
      end
    end
  end

  assign bus.busy    = (r_state != StIdle);
  assign bus.done    = r_done;
  assign bus.err     = r_err;
  assign bus.rstart  = (r_state == StIssue);
  assign bus.rsector = r_sector;
  assign bus.m_valid = w_fifo_valid;
  assign bus.m_data  = w_rdata[31:0];
  assign bus.m_last  = w_rdata[32];

endmodule

// File: tb/tb_sd_sector_streamer.sv
// Scoreboard bench: a reader model queues expected words, a monitor checks the output stream.
module tb_sd_sector_streamer;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  sd_sector_streamer_if bus ();

  sd_sector_streamer #(
    .FIFO_AW(8)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int          n_cmp = 0;
  int          n_fail = 0;
  logic [32:0] exp_q[$];
  int          pop_cnt = 0;
  logic [31:0] first_word = '0;
  logic [31:0] last_word = '0;
  logic        last_flag = 1'b0;
  int          ready_mode = 1;  // 0: low, 1: high, 2: toggle
  logic [7:0]  lanes[4];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, expv);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_busy"}, 64'(bus.busy), 64'd0);
    check({tag, "_done"}, 64'(bus.done), 64'd0);
    check({tag, "_err"}, 64'(bus.err), 64'd0);
    check({tag, "_rstart"}, 64'(bus.rstart), 64'd0);
    check({tag, "_m_valid"}, 64'(bus.m_valid), 64'd0);
    check({tag, "_m_last"}, 64'(bus.m_last), 64'd0);
    check({tag, "_rsector"}, 64'(bus.rsector), 64'd0);
    check({tag, "_m_data"}, 64'(bus.m_data), 64'd0);
  endtask

  task automatic start(input logic [31:0] sec, input logic [15:0] cnt);
    bus.cmd_start  = 1'b1;
    bus.cmd_sector = sec;
    bus.cmd_count  = cnt;
    @(posedge clk); #1;
    bus.cmd_start = 1'b0;
    check("busy_rise", 64'(bus.busy), 64'd1);
  endtask

  // Reader model: answers one rstart, streams the sector, queues the expected words.
  task automatic serve(input logic [31:0] exp_sec, input int off, input bit fin,
                       input int skip, input int stop_at);
    int         n;
    logic [7:0] b;
    n = 0;
    while (!bus.rstart && n < 3000) begin
      @(posedge clk); #1;
      n++;
    end
    if (!bus.rstart) begin
      n_cmp++;
      n_fail++;
      $display("FAIL rstart_timeout: got no rstart, expected sector 0x%08h", exp_sec);
      return;
    end
    check("rsector", 64'(bus.rsector), 64'(exp_sec));
    bus.rbusy = 1'b1;
    @(posedge clk); #1;
    check("rstart_fall", 64'(bus.rstart), 64'd0);
    for (int i = 0; i < 512; i++) begin
      if (i == stop_at) begin
        bus.outen = 1'b0;
        return;
      end
      if (i == skip) continue;
      b = 8'(i + off);
      bus.outen   = 1'b1;
      bus.outaddr = 9'(i);
      bus.outbyte = b;
      lanes[i % 4] = b;
      if (i % 4 == 3) exp_q.push_back({fin && (i == 511), lanes[3], lanes[2], lanes[1], lanes[0]});
      @(posedge clk); #1;
    end
    bus.outen = 1'b0;
    @(posedge clk); #1;
    bus.rdone = 1'b1;
    @(posedge clk); #1;
    bus.rdone = 1'b0;
    bus.rbusy = 1'b0;
  endtask

  task automatic wait_done(input string name, input int max);
    int n;
    n = 0;
    while (!bus.done && n < max) begin
      @(posedge clk); #1;
      n++;
    end
    check({name, "_done"}, 64'(bus.done), 64'd1);
    check({name, "_busy_low"}, 64'(bus.busy), 64'd0);
    check({name, "_q_empty"}, 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    bus.m_ready = 1'b0;
    forever begin
      @(posedge clk); #1;
      case (ready_mode)
        0:       bus.m_ready = 1'b0;
        1:       bus.m_ready = 1'b1;
        default: bus.m_ready = ~bus.m_ready;
      endcase
    end
  end

  // Monitor: pop on handshake, otherwise the stalled word must already equal the queue head.
  initial begin
    logic [32:0] got;
    forever begin
      @(negedge clk);
      if (!rst && bus.m_valid) begin
        got = {bus.m_last, bus.m_data};
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_fail++;
          $display("FAIL unexpected_word: got 0x%09h, expected no word", got);
        end else if (bus.m_ready) begin
          check("word", 64'(got), 64'(exp_q.pop_front()));
          if (pop_cnt == 0) first_word = bus.m_data;
          last_word = bus.m_data;
          last_flag = bus.m_last;
          pop_cnt++;
        end else begin
          check("stall_word", 64'(got), 64'(exp_q[0]));
        end
      end
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bit stall_rstart;
    bus.cmd_start = 1'b0; bus.cmd_sector = '0; bus.cmd_count = '0;
    bus.rbusy = 1'b0; bus.rdone = 1'b0; bus.outen = 1'b0;
    bus.outaddr = '0; bus.outbyte = '0;
    for (int i = 0; i < 4; i++) lanes[i] = '0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    check_reset_outputs("init");

    // Single sector, bytes equal their index.
    ready_mode = 1;
    pop_cnt = 0;
    start(32'd5, 16'd1);
    serve(32'd5, 0, 1'b1, -1, -1);
    wait_done("t1", 2000);
    check("t1_err", 64'(bus.err), 64'd0);
    check("t1_words", 64'(pop_cnt), 64'd128);
    check("t1_first", 64'(first_word), 64'h03020100);
    check("t1_last", 64'(last_word), 64'hFFFEFDFC);
    check("t1_last_flag", 64'(last_flag), 64'd1);

    // Three sectors across the sector-number wrap, consumer stalled.
    ready_mode = 0;
    pop_cnt = 0;
    start(32'hFFFF_FFFF, 16'd3);
    serve(32'hFFFF_FFFF, 0, 1'b0, -1, -1);
    serve(32'h0000_0000, 17, 1'b0, -1, -1);
    stall_rstart = 1'b0;
    repeat (200) begin
      @(posedge clk); #1;
      if (bus.rstart) stall_rstart = 1'b1;
    end
    check("t2_no_third_issue", 64'(stall_rstart), 64'd0);
    check("t2_busy", 64'(bus.busy), 64'd1);
    check("t2_words_held", 64'(exp_q.size()), 64'd256);
    ready_mode = 1;
    serve(32'h0000_0001, 34, 1'b1, -1, -1);
    wait_done("t2", 3000);
    check("t2_err", 64'(bus.err), 64'd0);
    check("t2_words", 64'(pop_cnt), 64'd384);

    // Consumer toggles ready every cycle.
    ready_mode = 2;
    pop_cnt = 0;
    start(32'd100, 16'd2);
    serve(32'd100, 5, 1'b0, -1, -1);
    serve(32'd101, 9, 1'b1, -1, -1);
    wait_done("t3", 3000);
    check("t3_err", 64'(bus.err), 64'd0);
    check("t3_words", 64'(pop_cnt), 64'd256);

    // Byte 100 never arrives: sticky error, transfer still completes.
    ready_mode = 1;
    pop_cnt = 0;
    start(32'd7, 16'd1);
    serve(32'd7, 0, 1'b1, 100, -1);
    wait_done("t4", 2000);
    check("t4_err", 64'(bus.err), 64'd1);
    check("t4_words", 64'(pop_cnt), 64'd128);
    repeat (5) @(posedge clk);
    #1;
    check("t4_err_sticky", 64'(bus.err), 64'd1);

    // Zero-count request clears err and finishes two cycles after cmd_start.
    start(32'h1234, 16'd0);
    check("t5_err_cleared", 64'(bus.err), 64'd0);
    check("t5_done_early", 64'(bus.done), 64'd0);
    check("t5_rstart_a", 64'(bus.rstart), 64'd0);
    @(posedge clk); #1;
    check("t5_done", 64'(bus.done), 64'd1);
    check("t5_busy_low", 64'(bus.busy), 64'd0);
    check("t5_rstart_b", 64'(bus.rstart), 64'd0);
    @(posedge clk); #1;
    check("t5_done_pulse", 64'(bus.done), 64'd0);

    // Reset in the middle of a sector, then a clean transfer.
    start(32'd20, 16'd1);
    serve(32'd20, 0, 1'b1, -1, 200);
    rst = 1'b1;
    bus.rbusy = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    exp_q.delete();
    for (int i = 0; i < 4; i++) lanes[i] = '0;
    check_reset_outputs("t6_rst");
    pop_cnt = 0;
    start(32'd9, 16'd1);
    serve(32'd9, 3, 1'b1, -1, -1);
    wait_done("t6", 2000);
    check("t6_err", 64'(bus.err), 64'd0);
    check("t6_words", 64'(pop_cnt), 64'd128);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
